serial_byte_deserializer: RTL and testbench
===========================================

// Module: serial_byte_deserializer
// PURPOSE
//  Consumes the serial lsb stream of the 8-bit shift register during right-shift operation.
//  Reassembles groups of WIDTH bits into parallel words and buffers them in a small FIFO.
//  Presents the words downstream with a valid/ready handshake.
//  Sticky flags report dropped words (overflow) and aborted partial words (frame error).
// PARAMETERS
//  WIDTH      8  bits per assembled word
//  FIFO_DEPTH 2  word buffer entries; power of 2, >=2
//  LSB_FIRST  1  1: first received bit -> data bit 0; 0: first received bit -> bit WIDTH-1
// PORTS
//  clock        in   1                    rising-edge clock
//  reset_n      in   1                    asynchronous, active-low reset
//  serial_in    in   1                    serial bit; connects to the shift register lsb output
//  bit_valid    in   1                    serial_in is sampled on this edge
//  frame_start  in   1                    qualifies the first bit of a word; ignored unless bit_valid=1
//  data_out     out  WIDTH                FIFO head word
//  data_valid   out  1                    FIFO not empty
//  data_ready   in   1                    consumer accepts; pop occurs when data_valid & data_ready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1 words held
//  overflow     out  1                    sticky: a completed word was dropped
//  frame_error  out  1                    sticky: a partial word was discarded
//  error_clear  in   1                    clears overflow and frame_error
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, bit count=0, FIFO empty.
//   data_out=0, data_valid=0, fifo_level=0, overflow=0, frame_error=0.
//  FSM IDLE:
//   bit_valid & frame_start: capture bit 0 of the word, count=1 -> COLLECT.
//   bit_valid & !frame_start: bit ignored, stay in IDLE.
//  FSM COLLECT:
//   Each bit_valid & !frame_start captures the next bit and increments count.
//   Bit WIDTH completes the word: push to FIFO, count=0 -> IDLE.
//   bit_valid & frame_start: discard the partial word, set frame_error.
//    That bit becomes bit 0 of a new word, count=1, stay in COLLECT.
//   Cycles with bit_valid=0 hold all state; gaps between bits are unlimited.
//  Bit placement: bit k (0-based arrival order) goes to data bit k if LSB_FIRST=1, else WIDTH-1-k.
//  Word completion latency:
//   The word completes on the edge that samples its final bit.
//   If the FIFO was empty, data_valid=1 and data_out=word in the following cycle.
//  FIFO:
//   Push succeeds if not full, or if a pop occurs on the same edge.
//   Push when full with no pop: word dropped, overflow set, contents unchanged.
//   Simultaneous push and pop: fifo_level unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH.
//  data_out is stable while data_valid=1 and data_ready=0.
//  data_out=0 when the FIFO is empty.
//  error_clear: clears both flags on the edge.
//   If an overflow or frame error occurs on the same edge, the set wins.
//  Reset asserted mid-word discards the partial word and all buffered words; no flag is set.
// TESTING
//  1 Reset, data_ready=1; bits 1,0,0,1,0,1,1,0 with frame_start on the first bit.
//    -> data_out=8'h69, data_valid=1 exactly one cycle after the 8th bit.
//  2 data_ready=0; send 8'hA5, 8'h3C, 8'hFF.
//    -> fifo_level=2, overflow=1.
//    -> Then data_ready=1 pops A5, then 3C; data_valid=0 afterwards.
//  3 Send 3 bits of a word, then frame_start with a new 8'h96 stream.
//    -> frame_error=1, output 8'h96.
//    -> error_clear then clears frame_error to 0.
//  4 FIFO full with data_ready=1; the 8th bit of a new word lands on the same edge as a pop.
//    -> No overflow, fifo_level stays 2, FIFO order preserved.
//  5 Bits with random 0-5 cycle bit_valid gaps, plus bit_valid bits sent with no frame_start in IDLE.
//    -> Only the framed words appear; no flags set.
//  6 reset_n low after 5 bits and with 1 word buffered.
//    -> All outputs 0 immediately; the next framed 8'h0F is output correctly.

Source files
------------

// File: rtl/serial_byte_deserializer.sv
// Serial-to-parallel word assembler feeding a small FIFO with a valid/ready output side.
// Sticky flags report dropped complete words and aborted partial words.
module serial_byte_deserializer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          serial_in,
  input  logic                          bit_valid,
  input  logic                          frame_start,
  output logic [WIDTH-1:0]              data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          error_clear
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        word_q, word_d;
  logic [WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_error_q, frame_error_d;
  logic                    push_s, push_ok_s, pop_s, full_s, drop_s, ferr_set_s;

  // Arrival index k lands on bit k (LSB first) or bit WIDTH-1-k (MSB first).
  function automatic logic [WIDTH-1:0] place_bit(input logic [WIDTH-1:0] word,
                                                 input logic [CW-1:0] idx,
                                                 input logic b);
    logic [WIDTH-1:0] w;
    w = word;
    if (LSB_FIRST) begin
      w[idx] = b;
    end else begin
      w[CW'(WIDTH-1) - idx] = b;
    end
    return w;
  endfunction

  // Word assembly state machine: next-state and completion strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            word_d  = place_bit({WIDTH{1'b0}}, {CW{1'b0}}, serial_in);
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            ferr_set_s = 1'b1;
            word_d     = place_bit({WIDTH{1'b0}}, {CW{1'b0}}, serial_in);
            cnt_d      = CW'(1);
          end else if (cnt_q == CW'(WIDTH-1)) begin
            word_d  = place_bit(word_q, cnt_q, serial_in);
            push_s  = 1'b1;
            cnt_d   = {CW{1'b0}};
            state_d = IDLE;
          end else begin
            word_d = place_bit(word_q, cnt_q, serial_in);
            cnt_d  = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO bookkeeping: a push into a full FIFO still succeeds when the head pops on the same edge.
  always_comb begin
    full_s    = (level_q == LW'(FIFO_DEPTH));
    pop_s     = (level_q != {LW{1'b0}}) & data_ready;
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    overflow_d    = drop_s | (overflow_q & ~error_clear);
    frame_error_d = ferr_set_s | (frame_error_q & ~error_clear);
  end

  // All sequential state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= {CW{1'b0}};
      word_q        <= {WIDTH{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      level_q       <= {LW{1'b0}};
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= word_d;
      end
    end
  end

  // Outputs come straight from registers; the head is masked to zero while empty.
  assign data_valid  = (level_q != {LW{1'b0}});
  assign data_out    = data_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Randomized and directed bench for serial_byte_deserializer against a queue-based reference model.
module tb_serial_byte_deserializer;
  localparam int W = 8;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         data_ready = 1'b0;
  logic         error_clear = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic [1:0]   fifo_level;
  logic         overflow;
  logic         frame_error;

  serial_byte_deserializer #(.WIDTH(W), .FIFO_DEPTH(D), .LSB_FIRST(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .fifo_level(fifo_level), .overflow(overflow),
    .frame_error(frame_error), .error_clear(error_clear)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits of the word in progress, buffered words, sticky flags.
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_in_frame = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_fifo.delete();
    m_in_frame = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_edge(input bit sin, input bit bv, input bit fs, input bit rdy, input bit clr);
    bit         pop, push, ferr_set, ovf_set;
    int         held;
    logic [7:0] word;
    held = m_fifo.size();
    pop = (held > 0) && rdy;
    push = 1'b0;
    ferr_set = 1'b0;
    ovf_set = 1'b0;
    word = 8'h00;
    if (bv) begin
      if (fs) begin
        if (m_in_frame) ferr_set = 1'b1;
        m_bits.delete();
        m_bits.push_back(sin);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_bits.push_back(sin);
      end
      if (m_in_frame && m_bits.size() == W) begin
        for (int k = 0; k < W; k++) word = word + (8'(m_bits[k]) << k);
        push = 1'b1;
        m_in_frame = 1'b0;
        m_bits.delete();
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (held < D || pop) m_fifo.push_back(word);
      else ovf_set = 1'b1;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_ferr = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    if (ferr_set) m_ferr = 1'b1;
  endtask

  task automatic check_outputs();
    logic [7:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
    check_value("data_valid", 32'(data_valid), 32'(m_fifo.size() > 0));
    check_value("data_out", 32'(data_out), 32'(head));
    check_value("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    check_value("overflow", 32'(overflow), 32'(m_ovf));
    check_value("frame_error", 32'(frame_error), 32'(m_ferr));
  endtask

  // Drive one cycle of inputs (from the falling edge), advance the model, check at the next falling edge.
  task automatic step(input bit sin, input bit bv, input bit fs, input bit rdy, input bit clr);
    serial_in = sin;
    bit_valid = bv;
    frame_start = fs;
    data_ready = rdy;
    error_clear = clr;
    @(posedge clock);
    model_edge(sin, bv, fs, rdy, clr);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy, input int max_gap);
    for (int k = 0; k < W; k++) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 0), rdy);
      step(w[k], 1'b1, k == 0, rdy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] w;
    repeat (2) @(negedge clock);
    check_outputs();
    reset_n = 1'b1;

    // 1: single word, visible one cycle after the final bit
    send_word(8'h69, 1'b1, 0);
    check_value("t1_word", 32'(data_out), 32'h69);
    check_value("t1_valid", 32'(data_valid), 32'h1);
    idle(2, 1'b1);

    // 2: stalled consumer, third word dropped, then drain in order
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b0, 0);
    send_word(8'hFF, 1'b0, 0);
    check_value("t2_level", 32'(fifo_level), 32'h2);
    check_value("t2_ovf", 32'(overflow), 32'h1);
    check_value("t2_head", 32'(data_out), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("t2_second", 32'(data_out), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_value("t2_empty", 32'(data_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 3: aborted partial word, then a complete one, then clear
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'h96, 1'b1, 0);
    check_value("t3_ferr", 32'(frame_error), 32'h1);
    check_value("t3_word", 32'(data_out), 32'h96);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_value("t3_clear", 32'(frame_error), 32'h0);
    idle(1, 1'b1);

    // 4: full FIFO, final bit coincides with a pop
    send_word(8'h11, 1'b0, 0);
    send_word(8'h22, 1'b0, 0);
    w = 8'h33;
    for (int k = 0; k < W; k++) step(w[k], 1'b1, k == 0, k == W - 1, 1'b0);
    check_value("t4_level", 32'(fifo_level), 32'h2);
    check_value("t4_ovf", 32'(overflow), 32'h0);
    check_value("t4_head", 32'(data_out), 32'h22);
    idle(3, 1'b1);

    // 5: random gaps and unframed noise bits in IDLE
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < int'($urandom_range(3, 0)); j++)
        step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      send_word(8'($urandom), 1'b1, 5);
    end
    idle(2, 1'b1);
    check_value("t5_ovf", 32'(overflow), 32'h0);
    check_value("t5_ferr", 32'(frame_error), 32'h0);

    // fully random inputs, including aborts, stalls and clears
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), ($urandom % 8) == 0, 1'($urandom), ($urandom % 16) == 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 6: asynchronous reset mid-word with a buffered word
    send_word(8'h5A, 1'b0, 0);
    w = 8'hC3;
    for (int k = 0; k < 5; k++) step(w[k], 1'b1, k == 0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    send_word(8'h0F, 1'b1, 0);
    check_value("t6_word", 32'(data_out), 32'h0F);
    check_value("t6_flags", 32'({overflow, frame_error}), 32'h0);
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
